rf_wb_arb: RTL and testbench

Write-back arbiter that shares the register file's limited write ports between the execution lanes and the memory-buffer release path. It sits between the alu/alu_mul result lanes and the register file write side. It grants lane results in program order (lane 0 oldest) into `WPORT` registered write ports, with memory release taking priority. It also suppresses same-cycle write-after-write duplicates and keeps a starvation counter that briefly holds off memory release.

---
 rtl/rf_wb_arb_pkg.sv | 16 +
 rtl/rf_wb_arb_prefix_grant.sv | 81 ++++++++
 rtl/rf_wb_arb.sv | 133 +++++++++++++
 tb/tb_rf_wb_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arb_pkg.sv
// Shared definitions for the register-file write-back arbiter.
// Lane count, data width and register index width live here so the
// execution lanes and the write-back side agree on them.
package rf_wb_arb_pkg;

    localparam int EXEC_LEN = 4;   // result lanes, lane 0 oldest
    localparam int XLEN     = 32;  // data width
    localparam int RGBIT    = 5;   // register index width
    localparam int STARVE_W = 4;   // starvation counter width

    // Width needed to index a write port (at least one bit).
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_wb_arb_prefix_grant.sv
// rfwb_prefix_grant: combinational in-order grant for the write-back lanes.
// Produces per-lane ready, the write-port slot each accepted lane lands in,
// and a kill bit for accepted lanes overwritten by a younger accepted lane
// in the same cycle. Memory release always owns port 0 when present.
module rfwb_prefix_grant
    import rf_wb_arb_pkg::*;
#(
    parameter int WPORT = 2,
    parameter int SW    = 1
) (
    input  logic                      i_mem_release,
    input  logic [RGBIT-1:0]          i_mem_sel,
    input  logic [EXEC_LEN-1:0]       i_lane_vld,
    input  logic [EXEC_LEN*RGBIT-1:0] i_lane_sel,
    output logic [EXEC_LEN-1:0]       o_lane_rdy,
    output logic [EXEC_LEN-1:0]       o_lane_acc,
    output logic [EXEC_LEN*SW-1:0]    o_lane_slot,
    output logic [EXEC_LEN-1:0]       o_lane_kill,
    output logic                      o_oldest_blocked
);

    logic [RGBIT-1:0] w_sel [EXEC_LEN];
    logic             w_blocked;
    logic             w_seen;
    logic             w_ok;
    int               w_used;

    // Unpack the flattened per-lane destinations.
    always_comb begin
        for (int i = 0; i < EXEC_LEN; i++) begin
            w_sel[i] = i_lane_sel[i*RGBIT +: RGBIT];
        end
    end

    // Walk lanes oldest-first; the first valid lane that cannot go blocks the rest.
    always_comb begin
        o_lane_rdy       = '0;
        o_lane_slot      = '0;
        o_oldest_blocked = 1'b0;
        w_blocked        = 1'b0;
        w_seen           = 1'b0;
        w_ok             = 1'b0;
        w_used           = i_mem_release ? 1 : 0;
        for (int i = 0; i < EXEC_LEN; i++) begin
            w_ok = !w_blocked
                && !(i_mem_release && (w_sel[i] == i_mem_sel))
                && ((w_sel[i] == '0) || (w_used < WPORT));
            o_lane_rdy[i] = w_ok;
            if (i_lane_vld[i]) begin
                if (w_ok) begin
                    // Zero destination passes through without taking a port.
                    if (w_sel[i] != '0) begin
                        o_lane_slot[i*SW +: SW] = SW'(w_used);
                        w_used = w_used + 1;
                    end
                end else begin
                    if (!w_seen) begin
                        o_oldest_blocked = 1'b1;
                    end
                    w_blocked = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    assign o_lane_acc = i_lane_vld & o_lane_rdy;

    // An accepted write shadowed by a younger accepted write to the same register is dropped.
    always_comb begin
        o_lane_kill = '0;
        for (int i = 0; i < EXEC_LEN; i++) begin
            for (int j = i + 1; j < EXEC_LEN; j++) begin
                if (o_lane_acc[i] && o_lane_acc[j] && (w_sel[i] != '0) && (w_sel[i] == w_sel[j])) begin
                    o_lane_kill[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: shares WPORT registered register-file write ports between the
// memory release path (highest priority, port 0) and the execution lanes
// (in-order prefix grant). Handshake: a lane transfers in a cycle where
// i_lane_vld[i] & o_lane_rdy[i]; an unaccepted lane holds sel/data stable,
// and the memory path cannot be back-pressured. Results appear on o_wr_*
// one cycle after acceptance.
// Optional feature macro: RFWB_STARVE_GUARD_EN enables the starvation
// counter and the o_mem_stall request; without it o_mem_stall is 0.
module rf_wb_arb
    import rf_wb_arb_pkg::*;
#(
    parameter int WPORT      = 2,
    parameter int STARVE_MAX = 3,
    localparam int CNT_W     = $clog2(EXEC_LEN + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_mem_release,
    input  logic [RGBIT-1:0]          i_mem_sel,
    input  logic [XLEN-1:0]           i_mem_data,
    input  logic [EXEC_LEN-1:0]       i_lane_vld,
    input  logic [EXEC_LEN*RGBIT-1:0] i_lane_sel,
    input  logic [EXEC_LEN*XLEN-1:0]  i_lane_data,
    output logic [EXEC_LEN-1:0]       o_lane_rdy,
    output logic [CNT_W-1:0]          o_wb_cnt,
    output logic [WPORT*RGBIT-1:0]    o_wr_sel,
    output logic [WPORT*XLEN-1:0]     o_wr_data,
    output logic                      o_mem_stall,
    output logic [STARVE_W-1:0]       o_starve_cnt
);

    localparam int SW = slot_w(WPORT);

    logic [EXEC_LEN-1:0]    w_lane_acc;
    logic [EXEC_LEN*SW-1:0] w_lane_slot;
    logic [EXEC_LEN-1:0]    w_lane_kill;
    logic                   w_oldest_blocked;
    logic [WPORT*RGBIT-1:0] w_nxt_sel;
    logic [WPORT*XLEN-1:0]  w_nxt_data;
    logic [WPORT*RGBIT-1:0] r_wr_sel;
    logic [WPORT*XLEN-1:0]  r_wr_data;

    rfwb_prefix_grant #(
        .WPORT (WPORT),
        .SW    (SW)
    ) u_grant (
        .i_mem_release    (i_mem_release),
        .i_mem_sel        (i_mem_sel),
        .i_lane_vld       (i_lane_vld),
        .i_lane_sel       (i_lane_sel),
        .o_lane_rdy       (o_lane_rdy),
        .o_lane_acc       (w_lane_acc),
        .o_lane_slot      (w_lane_slot),
        .o_lane_kill      (w_lane_kill),
        .o_oldest_blocked (w_oldest_blocked)
    );

    // Count of lanes accepted this cycle, zero-destination lanes included.
    always_comb begin
        o_wb_cnt = '0;
        for (int i = 0; i < EXEC_LEN; i++) begin
            o_wb_cnt = o_wb_cnt + CNT_W'(w_lane_acc[i]);
        end
    end

    // Pack memory write into port 0 and accepted lanes into their granted slots.
    always_comb begin
        w_nxt_sel  = '0;
        w_nxt_data = '0;
        if (i_mem_release) begin
            w_nxt_sel[RGBIT-1:0] = i_mem_sel;
            w_nxt_data[XLEN-1:0] = i_mem_data;
        end
        for (int i = 0; i < EXEC_LEN; i++) begin
            if (w_lane_acc[i] && (i_lane_sel[i*RGBIT +: RGBIT] != '0) && !w_lane_kill[i]) begin
                w_nxt_sel[int'(w_lane_slot[i*SW +: SW])*RGBIT +: RGBIT] = i_lane_sel[i*RGBIT +: RGBIT];
                w_nxt_data[int'(w_lane_slot[i*SW +: SW])*XLEN +: XLEN]  = i_lane_data[i*XLEN +: XLEN];
            end
        end
    end

    // Output stage: register the packed write ports; reset discards pending writes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_sel  <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_sel  <= w_nxt_sel;
            r_wr_data <= w_nxt_data;
        end
    end

    assign o_wr_sel  = r_wr_sel;
    assign o_wr_data = r_wr_data;

`ifdef RFWB_STARVE_GUARD_EN
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_mem_stall;
    logic                w_starve_inc;
    logic [STARVE_W:0]   w_cnt_plus;

    // The oldest valid lane can only be held back by the memory path.
    assign w_starve_inc = i_mem_release & w_oldest_blocked;
    assign w_cnt_plus   = {1'b0, r_starve_cnt} + (STARVE_W+1)'(1);

    // Count consecutive memory-blocked cycles; raise a one-cycle stall at the limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
            r_mem_stall  <= 1'b0;
        end else if (r_mem_stall) begin
            r_starve_cnt <= '0;
            r_mem_stall  <= 1'b0;
        end else if (w_starve_inc) begin
            r_starve_cnt <= w_cnt_plus[STARVE_W-1:0];
            r_mem_stall  <= (w_cnt_plus >= (STARVE_W+1)'(STARVE_MAX));
        end else begin
            r_starve_cnt <= '0;
            r_mem_stall  <= 1'b0;
        end
    end

    assign o_mem_stall  = r_mem_stall;
    assign o_starve_cnt = r_starve_cnt;
`else
    logic w_unused_starve;

    assign w_unused_starve = w_oldest_blocked;
    assign o_mem_stall     = 1'b0;
    assign o_starve_cnt    = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios followed by randomized lane and
// memory traffic, all checked against a transaction-level reference model.
module tb_rf_wb_arb;
    import rf_wb_arb_pkg::*;

    localparam int WPORT      = 2;
    localparam int STARVE_MAX = 3;
    localparam int CW         = $clog2(EXEC_LEN + 1);
`ifdef RFWB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic                      mem_release = 1'b0;
    logic [RGBIT-1:0]          mem_sel = '0;
    logic [XLEN-1:0]           mem_data = '0;
    logic [EXEC_LEN-1:0]       lane_vld = '0;
    logic [EXEC_LEN*RGBIT-1:0] lane_sel = '0;
    logic [EXEC_LEN*XLEN-1:0]  lane_data = '0;
    logic [EXEC_LEN-1:0]       lane_rdy;
    logic [CW-1:0]             wb_cnt;
    logic [WPORT*RGBIT-1:0]    wr_sel;
    logic [WPORT*XLEN-1:0]     wr_data;
    logic                      mem_stall;
    logic [STARVE_W-1:0]       starve_cnt;

    int checks = 0;
    int errors = 0;

    // Stimulus state per lane.
    logic             lv [EXEC_LEN];
    logic [RGBIT-1:0] ls [EXEC_LEN];
    logic [XLEN-1:0]  ld [EXEC_LEN];

    // Reference model state.
    logic [RGBIT-1:0]    exp_sel  [WPORT];
    logic [XLEN-1:0]     exp_data [WPORT];
    logic                exp_stall;
    int                  exp_cnt;
    logic [EXEC_LEN-1:0] m_acc;
    logic [EXEC_LEN-1:0] obs_rdy;
    logic [CW-1:0]       obs_cnt;

    rf_wb_arb #(
        .WPORT      (WPORT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mem_release (mem_release),
        .i_mem_sel     (mem_sel),
        .i_mem_data    (mem_data),
        .i_lane_vld    (lane_vld),
        .i_lane_sel    (lane_sel),
        .i_lane_data   (lane_data),
        .o_lane_rdy    (lane_rdy),
        .o_wb_cnt      (wb_cnt),
        .o_wr_sel      (wr_sel),
        .o_wr_data     (wr_data),
        .o_mem_stall   (mem_stall),
        .o_starve_cnt  (starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lane(input int i, input logic v, input logic [RGBIT-1:0] s, input logic [XLEN-1:0] d);
        lv[i] = v;
        ls[i] = s;
        ld[i] = d;
    endtask

    task automatic drive();
        for (int i = 0; i < EXEC_LEN; i++) begin
            lane_vld[i]                 = lv[i];
            lane_sel[i*RGBIT +: RGBIT]  = ls[i];
            lane_data[i*XLEN +: XLEN]   = ld[i];
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < WPORT; p++) begin
            exp_sel[p]  = '0;
            exp_data[p] = '0;
        end
        exp_stall = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic check_regs(input string tag);
        logic [WPORT*RGBIT-1:0] flat;
        flat = '0;
        for (int p = 0; p < WPORT; p++) flat[p*RGBIT +: RGBIT] = exp_sel[p];
        chk({tag, "_wr_sel"}, 64'(wr_sel), 64'(flat));
        for (int p = 0; p < WPORT; p++) begin
            if (exp_sel[p] != '0) chk({tag, "_wr_data"}, 64'(wr_data[p*XLEN +: XLEN]), 64'(exp_data[p]));
        end
        chk({tag, "_mem_stall"}, 64'(mem_stall), 64'(exp_stall));
        chk({tag, "_starve_cnt"}, 64'(starve_cnt), 64'(exp_cnt));
    endtask

    // One clock: apply inputs, check combinational grant, clock, check registered ports.
    task automatic step(input string tag);
        logic [EXEC_LEN-1:0] rdy;
        int                  budget;
        bit                  stop;
        int                  oldest;
        int                  accq[$];
        logic [RGBIT-1:0]    psel[$];
        logic [XLEN-1:0]     pdat[$];
        bit                  starving;
        drive();
        budget = WPORT - (mem_release ? 1 : 0);
        stop   = 0;
        rdy    = '0;
        oldest = -1;
        for (int i = 0; i < EXEC_LEN; i++) begin
            if (!stop) begin
                bit ok;
                ok = !(mem_release && (ls[i] == mem_sel)) && ((ls[i] == 0) || (budget > 0));
                rdy[i] = ok;
                if (lv[i]) begin
                    if (oldest < 0) oldest = i;
                    if (ok) begin
                        accq.push_back(i);
                        if (ls[i] != 0) budget--;
                    end else begin
                        stop = 1;
                    end
                end
            end
        end
        if (mem_release) begin
            psel.push_back(mem_sel);
            pdat.push_back(mem_data);
        end
        for (int k = 0; k < accq.size(); k++) begin
            if (ls[accq[k]] != 0) begin
                bit dup;
                dup = 0;
                for (int k2 = k + 1; k2 < accq.size(); k2++) begin
                    if (ls[accq[k2]] == ls[accq[k]]) dup = 1;
                end
                psel.push_back(dup ? '0 : ls[accq[k]]);
                pdat.push_back(ld[accq[k]]);
            end
        end
        starving = (oldest >= 0) && mem_release && !((accq.size() > 0) && (accq[0] == oldest));
        m_acc = rdy & lane_vld;
        #2;
        obs_rdy = lane_rdy;
        obs_cnt = wb_cnt;
        chk({tag, "_lane_rdy"}, 64'(lane_rdy), 64'(rdy));
        chk({tag, "_wb_cnt"}, 64'(wb_cnt), 64'(accq.size()));
        @(posedge clk);
        for (int p = 0; p < WPORT; p++) begin
            exp_sel[p]  = (p < psel.size()) ? psel[p] : '0;
            exp_data[p] = (p < pdat.size()) ? pdat[p] : '0;
        end
`ifdef RFWB_STARVE_GUARD_EN
        if (exp_stall) begin
            exp_stall = 1'b0;
            exp_cnt   = 0;
        end else if (starving) begin
            exp_cnt   = exp_cnt + 1;
            exp_stall = (exp_cnt >= STARVE_MAX);
        end else begin
            exp_cnt = 0;
        end
`endif
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < EXEC_LEN; i++) lane(i, 1'b0, '0, '0);
        model_clear();
        drive();
        // Reset values.
        #2;
        chk("reset_wr_sel", 64'(wr_sel), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        chk("reset_mem_stall", 64'(mem_stall), 64'd0);
        chk("reset_starve_cnt", 64'(starve_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Grant without memory: four lanes, two ports.
        mem_release = 1'b0;
        lane(0, 1'b1, 5'd1, 32'h1111_0001);
        lane(1, 1'b1, 5'd2, 32'h1111_0002);
        lane(2, 1'b1, 5'd3, 32'h1111_0003);
        lane(3, 1'b1, 5'd4, 32'h1111_0004);
        step("grant_a");
        chk("grant_a_rdy_lit", 64'(obs_rdy), 64'b0011);
        chk("grant_a_cnt_lit", 64'(obs_cnt), 64'd2);
        chk("grant_a_wr_lit", 64'(wr_sel), 64'({5'd2, 5'd1}));
        lane(0, 1'b0, '0, '0);
        lane(1, 1'b0, '0, '0);
        step("grant_b");
        chk("grant_b_wr_lit", 64'(wr_sel), 64'({5'd4, 5'd3}));
        lane(2, 1'b0, '0, '0);
        lane(3, 1'b0, '0, '0);

        // Memory priority and zero destination.
        mem_release = 1'b1; mem_sel = 5'd5; mem_data = 32'h5555_0005;
        lane(0, 1'b1, 5'd6, 32'h6666_0006);
        lane(1, 1'b1, 5'd0, 32'h0000_0000);
        lane(2, 1'b1, 5'd7, 32'h7777_0007);
        step("memprio_a");
        chk("memprio_a_rdy_lit", 64'(obs_rdy), 64'b0011);
        chk("memprio_a_wr_lit", 64'(wr_sel), 64'({5'd6, 5'd5}));
        mem_release = 1'b0;
        lane(0, 1'b0, '0, '0);
        lane(1, 1'b0, '0, '0);
        step("memprio_b");
        chk("memprio_b_acc2", 64'(obs_rdy & 4'b0100), 64'b0100);
        chk("memprio_b_wr_lit", 64'(wr_sel), 64'({5'd0, 5'd7}));
        lane(2, 1'b0, '0, '0);

        // Memory register conflict blocks the younger lane too.
        mem_release = 1'b1; mem_sel = 5'd8; mem_data = 32'h8888_0008;
        lane(0, 1'b1, 5'd8, 32'hA8A8_0008);
        lane(1, 1'b1, 5'd9, 32'hA9A9_0009);
        step("conflict_a");
        chk("conflict_a_rdy_lit", 64'(obs_rdy[1:0]), 64'b00);
        chk("conflict_a_wr_lit", 64'(wr_sel), 64'({5'd0, 5'd8}));
        mem_release = 1'b0;
        step("conflict_b");
        lane(0, 1'b0, '0, '0);
        lane(1, 1'b0, '0, '0);

        // Same-cycle write-after-write: only the younger write survives.
        lane(0, 1'b1, 5'd10, 32'hAAAA_0001);
        lane(1, 1'b1, 5'd10, 32'hBBBB_0002);
        step("waw");
        chk("waw_acc_lit", 64'(obs_rdy[1:0]), 64'b11);
        chk("waw_wr_lit", 64'(wr_sel), 64'({5'd10, 5'd0}));
        chk("waw_data_lit", 64'(wr_data[2*XLEN-1:XLEN]), 64'h0000_0000_BBBB_0002);
        lane(0, 1'b0, '0, '0);
        lane(1, 1'b0, '0, '0);

        // Starvation: memory keeps hitting lane 0's register.
        mem_release = 1'b1; mem_sel = 5'd12; mem_data = 32'hCCCC_000C;
        lane(0, 1'b1, 5'd12, 32'hDDDD_000D);
        step("starve_1");
        step("starve_2");
        step("starve_3");
        chk("starve_pulse_lit", 64'(mem_stall), 64'(GUARD));
        step("starve_4");
        chk("starve_after_pulse_lit", 64'(mem_stall), 64'd0);
        chk("starve_cnt_clear_lit", 64'(starve_cnt), 64'd0);
        mem_release = 1'b0;
        step("starve_5");
        chk("starve_accept_lit", 64'(obs_rdy[0]), 64'd1);
        chk("starve_cnt_final_lit", 64'(starve_cnt), 64'd0);
        chk("starve_wr_lit", 64'(wr_sel), 64'({5'd0, 5'd12}));
        lane(0, 1'b0, '0, '0);

        // Randomized traffic; unaccepted lanes hold their payload.
        for (int i = 0; i < EXEC_LEN; i++) lane(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        for (int n = 0; n < 400; n++) begin
            mem_release = ($urandom_range(0, 2) == 0);
            mem_sel     = 5'($urandom_range(1, 7));
            mem_data    = $urandom;
            step("rand");
            for (int i = 0; i < EXEC_LEN; i++) begin
                if (!lv[i] || m_acc[i]) lane(i, ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
            end
        end

        // Asynchronous reset while the output stage holds a write.
        mem_release = 1'b0;
        for (int i = 0; i < EXEC_LEN; i++) lane(i, 1'b0, '0, '0);
        lane(0, 1'b1, 5'd3, 32'h3333_0003);
        step("pre_rst");
        chk("pre_rst_wr_lit", 64'(wr_sel), 64'({5'd0, 5'd3}));
        lane(0, 1'b0, '0, '0);
        drive();
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        check_regs("rst_async");
        chk("rst_async_wr_data", 64'(wr_data), 64'd0);
        @(posedge clk);
        #1;
        check_regs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        lane(0, 1'b1, 5'd9, 32'h9999_0009);
        step("post_rst");
        chk("post_rst_wr_lit", 64'(wr_sel), 64'({5'd0, 5'd9}));
        lane(0, 1'b0, '0, '0);
        step("post_rst_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
